ohsm_one_hot_fsm: RTL and testbench
===================================

# ohsm_one_hot_fsm

Five-state one-hot sequencer that advances one step per rising edge of a `start` request and reports its current state as a 3-bit binary code on `SGlobal`. It is a small control block used as a global phase indicator; downstream logic decodes `SGlobal`. The state register is one-hot internally. Illegal one-hot patterns are detected and recovered.

## Interface
- No parameters. State count (5) and encoding are fixed.
- `clk` input 1: single system clock. All state changes occur on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `start` input 1: advance request, synchronous to `clk`. Only its rising edge is significant.
- `SGlobal` output 3: binary code of the current state.

## Operation
- Internal state register `state[4:0]` is one-hot:
  - S0 = 00001, S1 = 00010, S2 = 00100, S3 = 01000, S4 = 10000.
- Internal register `start_d` holds `start` sampled on the previous cycle.
- Advance condition `adv = start & ~start_d`: a rising edge of `start`, detected in one cycle.
- Holding `start` high advances exactly once. `start` must return low for at least one sampled cycle before the next advance.
- Transitions on `adv`:
  - S0→S1, S1→S2, S2→S3, S3→S4.
  - S4→S0 (wrap-around).
- Without `adv`, the state holds.
- `SGlobal` is a combinational decode of `state`:
  - S0→000, S1→001, S2→010, S3→011, S4→100.
  - Any non-one-hot pattern (zero bits set or more than one bit set)→111.
- Illegal-state recovery: if `state` is not one-hot at a clock edge, the next state is S0, regardless of `adv`.
- Codes 101 and 110 never appear on `SGlobal`.
- Reset, on a rising edge with `reset`==0:
  - `state` = S0 (00001), `start_d` = 0, so `SGlobal` = 000.
  - Reset has priority over `adv` and over recovery.
- `start` is ignored while `reset` is low.

## Timing
- Latency: `start` is sampled 1 at edge N with `start_d`=0. `state` updates at edge N, and `SGlobal` shows the new code immediately after edge N (zero extra cycles, combinational decode).
- `start_d` updates every edge, including edges where the state holds.
- First edge after reset release: `start_d`=0. If `start` is already 1 at that edge, this counts as a rising edge and the state advances S0→S1.
- Reset asserted mid-sequence (in any of S1..S4): `SGlobal` = 000 after the first edge at which `reset` is sampled low.
- A 1-cycle `start` pulse and a multi-cycle `start` pulse produce identical results (one advance each).
- Illegal state: `SGlobal`=111 until the next edge, after which it is 000.
- No asynchronous paths. `SGlobal` is glitch-free relative to `clk` edges.

## Test plan
- Reset: hold `reset`=0 for 1 cycle with `start`=0, then release → `SGlobal`=000, and it holds 000 for 3 idle cycles.
- Sequence: after reset, apply four 1-cycle `start` pulses separated by 1 low cycle → `SGlobal` steps 000→001→010→011→100, each change right after the edge sampling `start`=1.
- Wrap and hold: from S4, hold `start`=1 for 5 cycles → `SGlobal`=000 after the first edge and stays 000. Drop `start`, then pulse it again → 001.
- Reset mid-operation: reach S3 (011), assert `reset`=0 together with `start`=1 → `SGlobal`=000 after that edge. Release with `start` still 1 → advances to 001 at the first released edge.
- Illegal state: force `state`=00110 via the bench → `SGlobal`=111. After one edge (any `start` value) → 000. Next `start` pulse → 001.

Source files
------------

// File: rtl/ohsm_one_hot_fsm_if.sv
// Bus bundle for the one-hot phase sequencer: the start request in, the
// binary phase code out.
interface ohsm_one_hot_fsm_if;
  logic       start;
  logic [2:0] SGlobal;

  modport master (output start, input  SGlobal);
  modport slave  (input  start, output SGlobal);
endinterface

// File: rtl/ohsm_one_hot_fsm.sv
// Five-phase one-hot sequencer: it steps once per rising edge of start and
// publishes the current phase as a 3-bit code, with illegal states reported as 111.
module ohsm_one_hot_fsm (
  input  logic                 clk,
  input  logic                 reset,
  ohsm_one_hot_fsm_if.slave    bus
);

  typedef enum logic [4:0] {
    S0 = 5'b00001,
    S1 = 5'b00010,
    S2 = 5'b00100,
    S3 = 5'b01000,
    S4 = 5'b10000
  } state_e;

  // The register is plain logic, not state_e, so that it can represent corrupted
  // patterns. The recovery logic has to see those patterns.
  logic [4:0] state_q, state_d;
  logic       start_q;
  logic       adv;
  logic [2:0] sglobal;

  assign adv = bus.start & ~start_q;

  // NOTE: every always_comb output gets a default first, and each case has a
  // default arm, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S0:      if (adv) state_d = S1;
      S1:      if (adv) state_d = S2;
      S2:      if (adv) state_d = S3;
      S3:      if (adv) state_d = S4;
      S4:      if (adv) state_d = S0;
      default: state_d = S0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples values from before the edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= bus.start;
    end
  end

  always_comb begin
    sglobal = 3'b111;
    case (state_q)
      S0:      sglobal = 3'd0;
      S1:      sglobal = 3'd1;
      S2:      sglobal = 3'd2;
      S3:      sglobal = 3'd3;
      S4:      sglobal = 3'd4;
      default: sglobal = 3'b111;
    endcase
  end

  assign bus.SGlobal = sglobal;

endmodule

// File: tb/tb_ohsm_one_hot_fsm.sv
// Self-checking bench for ohsm_one_hot_fsm: directed vector table, randomized run
// against a phase-counter model, and forced illegal-state recovery.
module tb_ohsm_one_hot_fsm;

  logic clk = 1'b0;
  logic reset;
  ohsm_one_hot_fsm_if bus ();

  ohsm_one_hot_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_v;
    logic       start_v;
    logic [2:0] exp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: a phase number 0..4 plus the previous start sample.
  int   m_phase = 0;
  logic m_prev  = 1'b0;

  task automatic check(input string name, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Drive inputs on the falling edge. Apply the model update at the rising edge.
  // Leave the sampling point 1 time unit after that rising edge.
  task automatic step(input logic r, input logic s);
    @(negedge clk);
    reset     = r;
    bus.start = s;
    @(posedge clk);
    if (!r) begin
      m_phase = 0;
      m_prev  = 1'b0;
    end else begin
      if (s && !m_prev) m_phase = (m_phase + 1) % 5;
      m_prev = s;
    end
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    reset     = 1'b0;
    bus.start = 1'b0;

    // Reset for one cycle, then idle.
    vecs.push_back('{1'b0, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 1'b0, 3'd0});
    // Four single-cycle pulses step through 000 to 100.
    vecs.push_back('{1'b1, 1'b1, 3'd1});
    vecs.push_back('{1'b1, 1'b0, 3'd1});
    vecs.push_back('{1'b1, 1'b1, 3'd2});
    vecs.push_back('{1'b1, 1'b0, 3'd2});
    vecs.push_back('{1'b1, 1'b1, 3'd3});
    vecs.push_back('{1'b1, 1'b0, 3'd3});
    vecs.push_back('{1'b1, 1'b1, 3'd4});
    vecs.push_back('{1'b1, 1'b0, 3'd4});
    // A wrap with start held for five cycles advances only once.
    for (int i = 0; i < 5; i++) vecs.push_back('{1'b1, 1'b1, 3'd0});
    vecs.push_back('{1'b1, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 1'b1, 3'd1});
    // Reach S3, then reset with start high.
    vecs.push_back('{1'b1, 1'b0, 3'd1});
    vecs.push_back('{1'b1, 1'b1, 3'd2});
    vecs.push_back('{1'b1, 1'b0, 3'd2});
    vecs.push_back('{1'b1, 1'b1, 3'd3});
    vecs.push_back('{1'b0, 1'b1, 3'd0});
    // The first released edge with start still high counts as a rising edge.
    vecs.push_back('{1'b1, 1'b1, 3'd1});
    vecs.push_back('{1'b1, 1'b1, 3'd1});
    vecs.push_back('{1'b1, 1'b0, 3'd1});

    foreach (vecs[i]) begin
      step(vecs[i].rst_v, vecs[i].start_v);
      check($sformatf("vec%0d", i), bus.SGlobal, vecs[i].exp);
    end

    // Randomized traffic compared against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) != 0), 1'($urandom_range(0, 1)));
      check($sformatf("rand%0d", i), bus.SGlobal, 3'(m_phase));
    end

    // Illegal-state recovery for several corrupted patterns.
    begin
      logic [4:0] bad [3];
      bad[0] = 5'b00110;
      bad[1] = 5'b00000;
      bad[2] = 5'b11000;
      for (int k = 0; k < 3; k++) begin
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        @(negedge clk);
        force dut.state_q = bad[k];
        #1;
        check($sformatf("illegal%0d_code", k), bus.SGlobal, 3'b111);
        release dut.state_q;
        bus.start = k[0];
        @(posedge clk);
        #1;
        m_phase = 0;
        m_prev  = k[0];
        check($sformatf("illegal%0d_recover", k), bus.SGlobal, 3'd0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check($sformatf("illegal%0d_next", k), bus.SGlobal, 3'd1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
